truth_table_checker: RTL and testbench

TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

---
 rtl/truth_table_checker.sv | 168 ++++++++++++++++
 tb/tb_truth_table_checker.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_checker.sv
// Truth-table checker: sweeps every input vector of a small combinational
// DUT in ascending order, holds each for SETTLE cycles, compares the DUT
// output against a latched expected table and reports mismatch statistics.
module truth_table_checker #(
    parameter int WIDTH  = 3,
    parameter int SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [(1<<WIDTH)-1:0] exp_table,
    input  logic                  dut_y,
    output logic [WIDTH-1:0]      vec_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [WIDTH:0]        err_count,
    output logic                  first_err_valid,
    output logic [WIDTH-1:0]      first_err_vec,
    output logic                  sample_valid,
    output logic [WIDTH-1:0]      sample_vec,
    output logic                  sample_y
);

    localparam int              NVEC        = 1 << WIDTH;
    localparam logic [WIDTH-1:0] LAST_VEC   = {WIDTH{1'b1}};
    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [WIDTH:0]  ERR_MAX     = (WIDTH+1)'(NVEC);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [NVEC-1:0]   exp_q, exp_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]  vec_q, vec_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [WIDTH:0]    err_q, err_d;
    logic              fev_q, fev_d;
    logic [WIDTH-1:0]  fevec_q, fevec_d;
    logic              sv_q, sv_d;
    logic [WIDTH-1:0]  svec_q, svec_d;
    logic              sy_q, sy_d;

    // Next-state and next-output computation for the sweep FSM.
    // sample_y is captured on the edge entering SAMPLE (after the full settle
    // time) and that captured value is what gets compared, so the logged
    // value always matches the judged value.
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        err_d   = err_q;
        fev_d   = fev_q;
        fevec_d = fevec_q;
        sv_d    = 1'b0;
        svec_d  = svec_q;
        sy_d    = sy_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    exp_d   = exp_table;
                    err_d   = '0;
                    fev_d   = 1'b0;
                    fevec_d = '0;
                    vec_d   = '0;
                    cnt_d   = 4'd0;
                    state_d = ST_WAIT;
                end else begin
                    state_d = state_q;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                    sv_d    = 1'b1;
                    svec_d  = vec_q;
                    sy_d    = dut_y;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_SAMPLE: begin
                if (sy_q != exp_q[vec_q]) begin
                    if (err_q < ERR_MAX) begin
                        err_d = err_q + {{WIDTH{1'b0}}, 1'b1};
                    end else begin
                        err_d = err_q;
                    end
                    if (!fev_q) begin
                        fev_d   = 1'b1;
                        fevec_d = vec_q;
                    end else begin
                        fev_d   = fev_q;
                    end
                end else begin
                    err_d = err_q;
                end
                if (vec_q == LAST_VEC) begin
                    state_d = ST_DONE;
                end else begin
                    vec_d   = vec_q + {{(WIDTH-1){1'b0}}, 1'b1};
                    cnt_d   = 4'd0;
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_WAIT) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
        pass_d = done_d && (err_d == '0);
    end

    // State and output registers with synchronous reset clearing everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            exp_q   <= '0;
            cnt_q   <= 4'd0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fev_q   <= 1'b0;
            fevec_q <= '0;
            sv_q    <= 1'b0;
            svec_q  <= '0;
            sy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fevec_q <= fevec_d;
            sv_q    <= sv_d;
            svec_q  <= svec_d;
            sy_q    <= sy_d;
        end
    end

    assign vec_out         = vec_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_valid = fev_q;
    assign first_err_vec   = fevec_q;
    assign sample_valid    = sv_q;
    assign sample_vec      = svec_q;
    assign sample_y        = sy_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Scoreboard testbench for truth_table_checker driving an emulated 3-input DUT.
module tb_truth_table_checker;

    localparam int W      = 3;
    localparam int S      = 2;
    localparam int NV     = 1 << W;
    localparam int LAT    = NV * (S + 1);

    typedef struct {
        logic [W-1:0] v;
        logic         y;
    } samp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [NV-1:0] exp_table = '0;
    logic          dut_y;
    logic [W-1:0]  vec_out;
    logic          busy, done, pass;
    logic [W:0]    err_count;
    logic          first_err_valid;
    logic [W-1:0]  first_err_vec;
    logic          sample_valid;
    logic [W-1:0]  sample_vec;
    logic          sample_y;

    int            checks = 0;
    int            failures = 0;
    int            mode = 0;      // 0 ideal AND, 1 stuck-at-0, 2 stuck-at-1
    samp_t         sb[$];
    int            exp_err;
    logic          exp_fev;
    logic [W-1:0]  exp_fvec;

    truth_table_checker #(.WIDTH(W), .SETTLE(S)) dut (
        .clk(clk), .rst(rst), .start(start), .exp_table(exp_table),
        .dut_y(dut_y), .vec_out(vec_out), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .first_err_valid(first_err_valid),
        .first_err_vec(first_err_vec), .sample_valid(sample_valid),
        .sample_vec(sample_vec), .sample_y(sample_y)
    );

    always #5 clk = ~clk;

    function automatic logic model_y(input int m, input logic [W-1:0] v);
        if (m == 1) return 1'b0;
        if (m == 2) return 1'b1;
        return &v;
    endfunction

    assign dut_y = model_y(mode, vec_out);

    // One clock; outputs sampled 1 time unit after the edge; scoreboard popped.
    task automatic step_cycle();
        samp_t e;
        @(posedge clk);
        #1;
        if (sample_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sample_unexpected: got vec=%0d y=%0b, required no sample", sample_vec, sample_y);
            end else begin
                e = sb.pop_front();
                if (sample_vec !== e.v || sample_y !== e.y) begin
                    failures++;
                    $display("FAIL sample: got vec=%0d y=%0b, required vec=%0d y=%0b",
                             sample_vec, sample_y, e.v, e.y);
                end
            end
        end
    endtask

    // Pulse start for one edge and load the scoreboard plus expected results.
    task automatic start_run(input logic [NV-1:0] tbl);
        logic [W-1:0] v;
        samp_t s;
        exp_table = tbl;
        exp_err = 0;
        exp_fev = 1'b0;
        exp_fvec = '0;
        for (int i = 0; i < NV; i++) begin
            v = W'(i);
            s.v = v;
            s.y = model_y(mode, v);
            sb.push_back(s);
            if (s.y != tbl[i]) begin
                if (!exp_fev) begin
                    exp_fev = 1'b1;
                    exp_fvec = v;
                end
                exp_err++;
            end
        end
        start = 1'b1;
        step_cycle();
        start = 1'b0;
    endtask

    // Step until done rises (bounded); returns edges counted since the start edge.
    task automatic wait_done(input int already, output int cyc);
        cyc = already;
        while (done !== 1'b1 && cyc < 300) begin
            step_cycle();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step_cycle();
        step_cycle();
        checks++;
        if ({vec_out, busy, done, pass, err_count, first_err_valid, first_err_vec,
             sample_valid, sample_vec, sample_y} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got vec=%0d busy=%0b done=%0b pass=%0b err=%0d fev=%0b sv=%0b, required all 0",
                     vec_out, busy, done, pass, err_count, first_err_valid, sample_valid);
        end
        rst = 1'b0;
        step_cycle();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold: got busy=%0b done=%0b, required 0 0", busy, done);
        end
    endtask

    // Common end-of-run checks for latency and result registers.
    task automatic check_results(input string tag, input int cyc);
        checks++;
        if (cyc != LAT) begin
            failures++;
            $display("FAIL %s_latency: got %0d, required %0d", tag, cyc, LAT);
        end
        checks++;
        if (err_count !== (W+1)'(exp_err) || pass !== (exp_err == 0)) begin
            failures++;
            $display("FAIL %s_err: got err=%0d pass=%0b, required err=%0d pass=%0b",
                     tag, err_count, pass, exp_err, exp_err == 0);
        end
        checks++;
        if (first_err_valid !== exp_fev || (exp_fev && first_err_vec !== exp_fvec)) begin
            failures++;
            $display("FAIL %s_first: got fev=%0b vec=%0d, required fev=%0b vec=%0d",
                     tag, first_err_valid, first_err_vec, exp_fev, exp_fvec);
        end
        checks++;
        if (sb.size() != 0 || busy !== 1'b0 || vec_out !== {W{1'b1}}) begin
            failures++;
            $display("FAIL %s_end: got pending=%0d busy=%0b vec=%0d, required 0 0 %0d",
                     tag, sb.size(), busy, vec_out, NV - 1);
        end
        // DONE must hold its results
        step_cycle();
        step_cycle();
        checks++;
        if (done !== 1'b1 || err_count !== (W+1)'(exp_err)) begin
            failures++;
            $display("FAIL %s_hold: got done=%0b err=%0d, required 1 %0d", tag, done, err_count, exp_err);
        end
    endtask

    task automatic test_ideal();
        int cyc;
        mode = 0;
        start_run(8'b1000_0000);
        checks++;
        if (busy !== 1'b1 || vec_out !== '0) begin
            failures++;
            $display("FAIL ideal_busy: got busy=%0b vec=%0d, required 1 0", busy, vec_out);
        end
        wait_done(0, cyc);
        check_results("ideal", cyc);
    endtask

    task automatic test_stuck0();
        int cyc;
        mode = 1;
        start_run(8'b1000_0000);
        wait_done(0, cyc);
        check_results("stuck0", cyc);
    endtask

    task automatic test_stuck1();
        int cyc;
        mode = 2;
        start_run(8'b1000_0000);
        wait_done(0, cyc);
        check_results("stuck1", cyc);
    endtask

    task automatic test_restart_from_done();
        int cyc;
        mode = 0;
        start_run(8'b1000_0000);
        checks++;
        if (err_count !== '0 || first_err_valid !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL restart_clear: got err=%0d fev=%0b done=%0b, required 0 0 0",
                     err_count, first_err_valid, done);
        end
        wait_done(0, cyc);
        check_results("restart", cyc);
    endtask

    task automatic test_start_ignored();
        int cyc;
        mode = 0;
        start_run(8'b1000_0000);
        for (int i = 0; i < 10; i++) step_cycle();
        checks++;
        if (vec_out !== 3'd3) begin
            failures++;
            $display("FAIL ignore_pos: got vec=%0d, required 3", vec_out);
        end
        start = 1'b1;
        exp_table = 8'b0000_0000;   // must not affect the run in progress
        step_cycle();
        start = 1'b0;
        wait_done(11, cyc);
        check_results("ignore", cyc);
    endtask

    task automatic test_rst_midrun();
        int cyc;
        int guard;
        mode = 0;
        start_run(8'b1000_0000);
        guard = 0;
        while (vec_out !== 3'd4 && guard < 100) begin
            step_cycle();
            guard++;
        end
        checks++;
        if (vec_out !== 3'd4) begin
            failures++;
            $display("FAIL midrst_reach: got vec=%0d, required 4", vec_out);
        end
        rst = 1'b1;
        start = 1'b1;               // reset wins over start
        step_cycle();
        rst = 1'b0;
        start = 1'b0;
        sb.delete();
        checks++;
        if ({vec_out, busy, done, pass, err_count, first_err_valid, first_err_vec,
             sample_valid, sample_vec, sample_y} !== '0) begin
            failures++;
            $display("FAIL midrst_zero: got vec=%0d busy=%0b done=%0b err=%0d svec=%0d, required all 0",
                     vec_out, busy, done, err_count, sample_vec);
        end
        step_cycle();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_idle: got busy=%0b, required 0", busy);
        end
        start_run(8'b1000_0000);
        wait_done(0, cyc);
        check_results("postrst", cyc);
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_stuck0();
        test_stuck1();
        test_restart_from_done();
        test_start_ignored();
        test_rst_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
